// File: rtl/parada_pkg.sv
// Shared types and constants for the soft-stop ramp controller.
// The package holds the FSM state enum, the per-level PWM duty in percent
// and the width of the dwell counter.
package parada_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S100   = 3'd1,
    S50    = 3'd2,
    S30    = 3'd3,
    PARADO = 3'd4
  } state_t;

  localparam int DUTY_30  = 30;
  localparam int DUTY_50  = 50;
  localparam int DUTY_100 = 100;

  // Dwell lengths of 1..8 ticks need a last index of 0..7.
  localparam int DWELL_W = 3;

  // Duty in percent driven while the FSM sits in a given state.
  function automatic int duty_pct(input state_t s);
    int pct;
    case (s)
      S100:    pct = DUTY_100;
      S50:     pct = DUTY_50;
      S30:     pct = DUTY_30;
      default: pct = 0;
    endcase
    return pct;
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Dwell-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// last count with a one-cycle tick. A clear restarts the count at 0 and
// wins over the enable, so a freshly entered level always gets a full tick.
module prescaler_tick #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick is gated by the enable so a paused ramp never sees a stale tick.
  assign tick = en && (cnt_q == LAST);

  // Next count: clear, hold while paused, otherwise wrap-around increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parada_rampa_parcial.sv
// Soft-stop ramp controller. On a stop request it latches the current speed
// level and steps it down 100 -> 50 -> 30 -> 0, spending N dwell ticks per
// level (N = DWELL_FAST with Rapido, DWELL_SLOW with Lento, paused with
// neither). All outputs are registered copies of the next-state decode, so
// they line up exactly with the state register.
// Optional feature: define PARADA_PWM_EN to build the PWM duty generator;
// without it pwm_out is tied low and no PWM counter exists.
module parada_rampa_parcial
  import parada_pkg::*;
#(
  parameter int TICK_DIV   = 10_000_000,
  parameter int DWELL_FAST = 1,
  parameter int DWELL_SLOW = 3,
  parameter int PWM_PERIOD = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic parar,
  input  logic Rapido,
  input  logic Lento,
  input  logic in_30,
  input  logic in_50,
  input  logic in_100,
  output logic out_30,
  output logic out_50,
  output logic out_100,
  output logic ocupado,
  output logic parado,
  output logic pwm_out
);

  if (DWELL_FAST < 1 || DWELL_FAST > 8 || DWELL_SLOW < 1 || DWELL_SLOW > 8 ||
      TICK_DIV < 1 || PWM_PERIOD < 1) begin : g_bad_params
    $error("parada_rampa_parcial: dwell lengths must be 1..8, TICK_DIV and PWM_PERIOD >= 1");
  end

  localparam logic [DWELL_W-1:0] FAST_LAST = DWELL_W'(DWELL_FAST - 1);
  localparam logic [DWELL_W-1:0] SLOW_LAST = DWELL_W'(DWELL_SLOW - 1);

  state_t               state_q;
  state_t               state_d;
  logic [DWELL_W-1:0]   dwell_cnt_q;
  logic [DWELL_W-1:0]   dwell_cnt_d;
  logic [DWELL_W-1:0]   dwell_last;
  logic                 dwell_run;
  logic                 ramping;
  logic                 state_change;
  logic                 tick;

  logic out_30_q, out_50_q, out_100_q, ocupado_q, parado_q;
  logic out_30_d, out_50_d, out_100_d, ocupado_d, parado_d;

  // Dwell length is re-sampled every cycle; Rapido wins over Lento and
  // neither selected means the ramp is paused.
  always_comb begin
    dwell_run  = 1'b0;
    dwell_last = '0;
    if (Rapido) begin
      dwell_run  = 1'b1;
      dwell_last = FAST_LAST;
    end else if (Lento) begin
      dwell_run  = 1'b1;
      dwell_last = SLOW_LAST;
    end
  end

  assign ramping      = (state_q == S100) || (state_q == S50) || (state_q == S30);
  assign state_change = (state_d != state_q);

  prescaler_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (ramping && dwell_run),
    .clr   (state_change),
    .tick  (tick)
  );

  // Next-state logic. Using >= on the dwell count means a shortened dwell
  // takes effect on the very next tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (parar) begin
          if (in_100)      state_d = S100;
          else if (in_50)  state_d = S50;
          else if (in_30)  state_d = S30;
          else             state_d = PARADO;
        end
      end
      S100: begin
        if (!parar)                              state_d = IDLE;
        else if (tick && dwell_cnt_q >= dwell_last) state_d = S50;
      end
      S50: begin
        if (!parar)                              state_d = IDLE;
        else if (tick && dwell_cnt_q >= dwell_last) state_d = S30;
      end
      S30: begin
        if (!parar)                              state_d = IDLE;
        else if (tick && dwell_cnt_q >= dwell_last) state_d = PARADO;
      end
      PARADO: begin
        if (!parar) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Dwell counter: cleared on every state entry, advanced once per tick.
  always_comb begin
    dwell_cnt_d = dwell_cnt_q;
    if (state_change) begin
      dwell_cnt_d = '0;
    end else if (tick) begin
      dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
    end
  end

  // Output decode from the next state, registered alongside the state.
  always_comb begin
    out_100_d = (state_d == S100);
    out_50_d  = (state_d == S50);
    out_30_d  = (state_d == S30);
    ocupado_d = (state_d == S100) || (state_d == S50) || (state_d == S30);
    parado_d  = (state_d == PARADO);
  end

  // State, dwell counter and level output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dwell_cnt_q <= '0;
      out_100_q   <= 1'b0;
      out_50_q    <= 1'b0;
      out_30_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      parado_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      out_100_q   <= out_100_d;
      out_50_q    <= out_50_d;
      out_30_q    <= out_30_d;
      ocupado_q   <= ocupado_d;
      parado_q    <= parado_d;
    end
  end

  assign out_100 = out_100_q;
  assign out_50  = out_50_q;
  assign out_30  = out_30_q;
  assign ocupado = ocupado_q;
  assign parado  = parado_q;

`ifdef PARADA_PWM_EN
  localparam int PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);

  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] pwm_cnt_d;
  logic [PWM_W:0]   duty_d;
  logic             pwm_out_q;
  logic             pwm_out_d;

  // PWM counter restarts with every state change; duty follows the next state.
  always_comb begin
    if (state_change || pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end
    duty_d    = (PWM_W + 1)'(PWM_PERIOD * duty_pct(state_d) / 100);
    pwm_out_d = ({1'b0, pwm_cnt_d} < duty_d);
  end

  // PWM counter and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: doc/parada_rampa_parcial.md
# parada_rampa_parcial

Soft-stop ramp controller: the deceleration counterpart of the staged start ramp. On a stop request it takes the motor's current speed level (100 / 50 / 30 %) and steps it down 100→50→30→0. Each step has a dwell time selected by the Rapido/Lento switches. It sits beside the start-ramp FSM under the Tiny Tapeout top, which selects this block's level outputs while `ocupado` is high.

## Interface
Parameters:
- TICK_DIV, 10_000_000: clk cycles per dwell tick (1 Hz at 10 MHz).
- DWELL_FAST, 1: ticks spent per level when Rapido.
- DWELL_SLOW, 3: ticks spent per level when Lento.
- PWM_PERIOD, 100: PWM counter period in clk cycles (only used with PARADA_PWM_EN).

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- parar  input  1  stop request, level-sensitive.
- Rapido  input  1  fast dwell select; has priority over Lento.
- Lento  input  1  slow dwell select.
- in_30, in_50, in_100  input  1 each  current speed level from the start-ramp FSM.
- out_30, out_50, out_100  output  1 each  one-hot ramped level; all 0 when stopped or idle.
- ocupado  output  1  ramp in progress (states S100/S50/S30).
- parado  output  1  ramp finished; motor at 0.
- pwm_out  output  1  duty-cycle output for the current level.

## Operation
- States: IDLE, S100, S50, S30, PARADO.
- IDLE: all outputs 0.
  - parar=1 latches the start level with priority in_100 > in_50 > in_30 and moves to the matching state.
  - If no input level is set, go straight to PARADO.
- In S100/S50/S30: the out_* bit for the level is 1, and ocupado=1.
- Dwell length N is DWELL_FAST if Rapido=1, else DWELL_SLOW if Lento=1.
  - If both are 0, the ramp pauses: tick and dwell counters freeze and the level is held.
- Level change happens on the cycle where tick=1 and dwell_cnt==N-1.
  - S100→S50, S50→S30, S30→PARADO.
  - Both counters clear on every state entry.
- N is sampled every cycle. If N changes mid-dwell so that dwell_cnt≥N-1, the level changes on the next tick.
- PARADO: parado=1 and all levels are 0. It returns to IDLE on the first cycle parar=0.
- parar=0 in S100/S50/S30 aborts the ramp: next state is IDLE and all outputs drop to 0.
- Tick counter counts 0..TICK_DIV-1. `tick` is high for one cycle at TICK_DIV-1.
- Dwell counter is 3 bits wide. DWELL_FAST and DWELL_SLOW must both be in 1..8.

## Timing
- Every output is registered and decoded from the state register.
- Reset value of every output is 0. Reset clears the state to IDLE and both counters to 0.
- Latency:
  - parar sampled high in IDLE → level visible 1 cycle later.
  - Time spent in each level is exactly N×TICK_DIV cycles, excluding paused cycles.
- Reset asserted mid-ramp: IDLE on the next edge, and all outputs are 0 in the following cycle.
- Input levels are sampled only on the IDLE exit cycle. Later changes on in_* are ignored.

## Configuration
- PARADA_PWM_EN defined:
  - PWM counter runs 0..PWM_PERIOD-1 and restarts on state change.
  - pwm_out = (pwm_cnt < duty).
  - duty = 100%, 50%, 30% or 0% of PWM_PERIOD for S100, S50, S30 and IDLE/PARADO respectively.
- PARADA_PWM_EN undefined: no PWM counter is built and pwm_out is tied to 0.

## Structure
- Package parada_pkg contains:
  - the state enum;
  - the duty constants DUTY_30, DUTY_50, DUTY_100 as percent;
  - the dwell counter width.
- Sub-module prescaler_tick(clk, reset, en, clr, tick) holds the TICK_DIV counter.
- The FSM, dwell counter and PWM logic stay in the top module.

## Test plan
All scenarios use TICK_DIV=4, DWELL_FAST=1, DWELL_SLOW=3, PWM_PERIOD=10.
- Fast full ramp. Stimulus: in_100=1, Rapido=1, parar=1. Response: out_100 for 4 cycles, out_50 for 4, out_30 for 4, then parado=1; ocupado high for exactly 12 cycles.
- Slow ramp from 50. Stimulus: in_50=1, Lento=1. Response: out_50 for 12 cycles, out_30 for 12, then parado.
- Pause. Stimulus: Rapido and Lento cleared for 20 cycles in S50. Response: out_50 held, then the remaining dwell completes unchanged.
- Abort and reset mid-ramp.
  - parar=0 in S50: outputs 0 and IDLE next cycle.
  - reset=1 in S30: all outputs 0 one cycle after the edge.
- No level present. Stimulus: parar=1 with all in_*=0. Response: parado=1 next cycle, ocupado never asserted. Deasserting parar returns the block to IDLE.
- PWM with PARADA_PWM_EN. Response: pwm_out high 10/10 cycles in S100, 5/10 in S50, 3/10 in S30, and 0 in PARADO.
